// File: rtl/tx.sv
// -----------------------------------------------------------------------------
// tx -- gPTP Sync transmit engine with egress-timestamp table.
//
// A requester presents an entry index and an originTimestamp. The block
// builds a 44-byte Sync message and hands it to the MAC over a valid/ready
// channel. It then waits for the MAC to return the egress timestamp and stores
// that timestamp in a 256-entry table at the requested index.
//
// Optional feature macro: GPTP_TX_TIMEOUT_EN
//   When it is defined, a transaction that waits longer than TIMEOUT_CYCLES
//   for the egress timestamp is abandoned.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   gptp_rd_addr  [7:0] timestamp-table read address
//   gptp_rd_data [79:0] table entry {seconds[79:32], nanoseconds[31:0]}, 1-cycle latency
//   gptp_wr_addr  [7:0] request entry index, also the sequenceId low byte
//   gptp_wr_data [79:0] originTimestamp for the request
//   gptp_wr_vaild       transmit request
//   gptp_wr_vaild_ready one-cycle pulse when a request is accepted
//   gptp_wr_ready       one-cycle pulse when the egress timestamp has been stored
//   gptp_ts_vaild       message valid to the MAC
//   gptp_ts_ready       message ready from the MAC
//   gptp_ts_data[351:0] Sync message to the MAC
//   gptp_ts_rv_vaild    egress timestamp valid from the MAC
//   gptp_ts_rv_data     egress timestamp from the MAC
// -----------------------------------------------------------------------------
module tx #(
    parameter logic [63:0] CLOCK_IDENTITY = 64'h0,
    parameter logic [15:0] PORT_NUMBER    = 16'd1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   gptp_rd_addr,
    output logic [79:0]  gptp_rd_data,
    input  logic [7:0]   gptp_wr_addr,
    input  logic [79:0]  gptp_wr_data,
    input  logic         gptp_wr_vaild,
    output logic         gptp_wr_vaild_ready,
    output logic         gptp_wr_ready,
    output logic         gptp_ts_vaild,
    input  logic         gptp_ts_ready,
    output logic [351:0] gptp_ts_data,
    input  logic         gptp_ts_rv_vaild,
    input  logic [79:0]  gptp_ts_rv_data
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t         r_state;
    logic [7:0]     r_addr;
    logic [79:0]    r_data;
    logic [351:0]   r_ts_data;
    logic           r_ts_vaild;
    logic           r_wr_vaild_ready;
    logic           r_wr_ready;
    logic [79:0]    r_rd_data;
    logic [79:0]    r_table [256];
    logic           w_tbl_we;

`ifdef GPTP_TX_TIMEOUT_EN
    logic [31:0]    r_wait_cnt;
`else
    logic           w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Sync message: header (34 bytes) followed by the 10-byte originTimestamp.
    function automatic logic [351:0] build_msg(input logic [7:0] a, input logic [79:0] d);
        return {8'h10, 8'h02, 16'd44, 8'h00, 8'h00, 16'h0200, 64'h0, 32'h0,
                CLOCK_IDENTITY, PORT_NUMBER, 8'h00, a, 8'h00, 8'hFD, d};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_addr           <= '0;
            r_data           <= '0;
            r_ts_data        <= '0;
            r_ts_vaild       <= 1'b0;
            r_wr_vaild_ready <= 1'b0;
            r_wr_ready       <= 1'b0;
`ifdef GPTP_TX_TIMEOUT_EN
            r_wait_cnt       <= '0;
`endif
        end else begin
            r_wr_vaild_ready <= 1'b0;
            r_wr_ready       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (gptp_wr_vaild) begin
                        r_addr           <= gptp_wr_addr;
                        r_data           <= gptp_wr_data;
                        r_ts_data        <= build_msg(gptp_wr_addr, gptp_wr_data);
                        r_ts_vaild       <= 1'b1;
                        r_wr_vaild_ready <= 1'b1;
                        r_state          <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_ts_vaild && gptp_ts_ready) begin
                        r_ts_vaild <= 1'b0;
                        r_state    <= S_WAIT;
`ifdef GPTP_TX_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (gptp_ts_rv_vaild) begin
                        r_wr_ready <= 1'b1;
                        r_state    <= S_DONE;
                    end
`ifdef GPTP_TX_TIMEOUT_EN
                    // Counter holds the number of WAIT cycles already spent;
                    // leaving once it reaches the limit means the limit was exceeded.
                    else if (r_wait_cnt >= TIMEOUT_CYCLES) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_tbl_we = (r_state == S_WAIT) && gptp_ts_rv_vaild;

    // Read samples the pre-write contents, so a same-cycle read returns the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 256; i++) begin
                r_table[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_table[gptp_rd_addr];
            if (w_tbl_we) begin
                r_table[r_addr] <= gptp_ts_rv_data;
            end
        end
    end

    assign gptp_rd_data        = r_rd_data;
    assign gptp_ts_data        = r_ts_data;
    assign gptp_ts_vaild       = r_ts_vaild;
    assign gptp_wr_vaild_ready = r_wr_vaild_ready;
    assign gptp_wr_ready       = r_wr_ready;

endmodule

// File: tb/tb_tx.sv
`timescale 1ns/1ps

module tb_tx;

  localparam logic [63:0] CID  = 64'h0011_2233_4455_6677;
  localparam logic [15:0] PNUM = 16'h0007;

  logic         clk;
  logic         reset;
  logic [7:0]   gptp_rd_addr;
  logic [79:0]  gptp_rd_data;
  logic [7:0]   gptp_wr_addr;
  logic [79:0]  gptp_wr_data;
  logic         gptp_wr_vaild;
  logic         gptp_wr_vaild_ready;
  logic         gptp_wr_ready;
  logic         gptp_ts_vaild;
  logic         gptp_ts_ready;
  logic [351:0] gptp_ts_data;
  logic         gptp_ts_rv_vaild;
  logic [79:0]  gptp_ts_rv_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [79:0] model [256];

  tx #(
    .CLOCK_IDENTITY(CID),
    .PORT_NUMBER   (PNUM),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .gptp_rd_addr       (gptp_rd_addr),
    .gptp_rd_data       (gptp_rd_data),
    .gptp_wr_addr       (gptp_wr_addr),
    .gptp_wr_data       (gptp_wr_data),
    .gptp_wr_vaild      (gptp_wr_vaild),
    .gptp_wr_vaild_ready(gptp_wr_vaild_ready),
    .gptp_wr_ready      (gptp_wr_ready),
    .gptp_ts_vaild      (gptp_ts_vaild),
    .gptp_ts_ready      (gptp_ts_ready),
    .gptp_ts_data       (gptp_ts_data),
    .gptp_ts_rv_vaild   (gptp_ts_rv_vaild),
    .gptp_ts_rv_data    (gptp_ts_rv_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected message assembled field by field at byte offsets.
  function automatic logic [351:0] exp_msg(input logic [7:0] a, input logic [79:0] d);
    logic [351:0] m;
    m = '0;
    m[351:344] = 8'h10;         // messageType Sync, transportSpecific 1
    m[343:336] = 8'h02;         // versionPTP
    m[335:320] = 16'd44;        // messageLength
    m[303:288] = 16'h0200;      // flagField (twoStep)
    m[191:128] = CID;
    m[127:112] = PNUM;
    m[111:96]  = {8'h00, a};    // sequenceId
    m[87:80]   = 8'hFD;         // logMessageInterval
    m[79:0]    = d;
    return m;
  endfunction

  function automatic logic [79:0] rand80();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic readback(input logic [7:0] a);
    gptp_rd_addr = a;
    step();
    chk("readback", gptp_rd_data, model[a]);
  endtask

  // One full request. Ends in the cycle where gptp_wr_ready is high.
  task automatic do_txn(input logic [7:0] a, input logic [79:0] d,
                        input int unsigned rdy_dly, input int unsigned rv_dly,
                        input logic [79:0] rvd, input bit hold, input bit from_done);
    logic [351:0] m;
    logic [79:0]  old;
    m = exp_msg(a, d);
    gptp_wr_addr  = a;
    gptp_wr_data  = d;
    gptp_wr_vaild = 1'b1;
    if (from_done) begin
      step();
      chk("b2b_gap", {gptp_wr_vaild_ready, gptp_wr_ready}, 2'b00);
    end
    step();
    chk("accept_pulse", gptp_wr_vaild_ready, 1'b1);
    chk("ts_vaild_rise", gptp_ts_vaild, 1'b1);
    chk("ts_data", gptp_ts_data, m);
    if (!hold) gptp_wr_vaild = 1'b0;
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      step();
      chk("send_hold", {gptp_ts_vaild, gptp_wr_vaild_ready}, 2'b10);
      chk("ts_data_stable", gptp_ts_data, m);
    end
    gptp_ts_ready = 1'b1;
    step();
    gptp_ts_ready = 1'b0;
    chk("ts_vaild_drop", gptp_ts_vaild, 1'b0);
    for (int unsigned i = 0; i < rv_dly; i++) begin
      if (i == 0 && !hold) begin
        // A request during WAIT must be ignored.
        gptp_wr_vaild = 1'b1;
        gptp_wr_addr  = a ^ 8'h01;
        gptp_wr_data  = ~d;
      end
      step();
      gptp_wr_vaild = hold;
      gptp_wr_addr  = a;
      gptp_wr_data  = d;
      chk("wait_quiet", {gptp_wr_ready, gptp_wr_vaild_ready, gptp_ts_vaild}, 3'b000);
    end
    old = model[a];
    gptp_rd_addr     = a;
    gptp_ts_rv_vaild = 1'b1;
    gptp_ts_rv_data  = rvd;
    step();
    gptp_ts_rv_vaild = 1'b0;
    chk("wr_ready_pulse", gptp_wr_ready, 1'b1);
    chk("rd_old_on_write", gptp_rd_data, old);
    model[a] = rvd;
  endtask

  initial begin
    logic [7:0]  a1, a2;
    logic [79:0] d;
    int          seen;

    for (int unsigned i = 0; i < 256; i++) model[i] = '0;
    reset            = 1'b1;
    gptp_rd_addr     = '0;
    gptp_wr_addr     = '0;
    gptp_wr_data     = '0;
    gptp_wr_vaild    = 1'b0;
    gptp_ts_ready    = 1'b0;
    gptp_ts_rv_vaild = 1'b0;
    gptp_ts_rv_data  = '0;

    step();
    step();
    chk("reset_flags", {gptp_wr_vaild_ready, gptp_wr_ready, gptp_ts_vaild}, 3'b000);
    chk("reset_ts_data", gptp_ts_data, 352'h0);
    chk("reset_rd_data", gptp_rd_data, 80'h0);
    reset = 1'b0;
    step();

    // Directed transaction: addr 1, ready held off for 5 cycles.
    do_txn(8'd1, 80'h123456789abc00000001, 5, 2, 80'h123456789abc00000020, 1'b0, 1'b0);
    step();
    chk("done_one_cycle", gptp_wr_ready, 1'b0);
    readback(8'd1);

    // Egress timestamp in IDLE is ignored.
    gptp_ts_rv_vaild = 1'b1;
    gptp_ts_rv_data  = 80'hFF;
    step();
    gptp_ts_rv_vaild = 1'b0;
    chk("idle_rv_ignored", gptp_wr_ready, 1'b0);
    readback(8'd1);

    // Randomized transactions.
    for (int unsigned k = 0; k < 6; k++) begin
      a1 = 8'($urandom_range(0, 255));
      do_txn(a1, rand80(), $urandom_range(0, 4), $urandom_range(1, 4), rand80(), 1'b0, 1'b0);
      step();
      chk("done_one_cycle", gptp_wr_ready, 1'b0);
      readback(a1);
    end

    // Back-to-back with the request held high.
    a1 = 8'($urandom_range(0, 127));
    a2 = 8'($urandom_range(128, 255));
    do_txn(a1, rand80(), $urandom_range(0, 3), $urandom_range(1, 3), rand80(), 1'b1, 1'b0);
    do_txn(a2, rand80(), $urandom_range(0, 3), $urandom_range(1, 3), rand80(), 1'b0, 1'b1);
    step();
    chk("done_one_cycle", gptp_wr_ready, 1'b0);
    readback(a1);
    readback(a2);

    // Long WAIT with no egress timestamp.
    gptp_wr_addr  = 8'd2;
    gptp_wr_data  = rand80();
    gptp_wr_vaild = 1'b1;
    step();
    gptp_wr_vaild = 1'b0;
    chk("accept_pulse", gptp_wr_vaild_ready, 1'b1);
    gptp_ts_ready = 1'b1;
    step();
    gptp_ts_ready = 1'b0;
    seen = 0;
    repeat (1100) begin
      step();
      if (gptp_wr_ready) seen++;
    end
    chk("long_wait_no_ready", seen, 0);
    d = rand80();
    gptp_ts_rv_vaild = 1'b1;
    gptp_ts_rv_data  = d;
    step();
    gptp_ts_rv_vaild = 1'b0;
`ifdef GPTP_TX_TIMEOUT_EN
    chk("timeout_no_ready", gptp_wr_ready, 1'b0);
`else
    chk("late_rv_ready", gptp_wr_ready, 1'b1);
    model[2] = d;
`endif
    step();
    readback(8'd2);

    // Reset while in WAIT aborts the transaction and clears the table.
    gptp_wr_addr  = 8'd1;
    gptp_wr_data  = rand80();
    gptp_wr_vaild = 1'b1;
    step();
    gptp_wr_vaild = 1'b0;
    gptp_ts_ready = 1'b1;
    step();
    gptp_ts_ready = 1'b0;
    step();
    reset            = 1'b1;
    gptp_ts_rv_vaild = 1'b1;
    gptp_ts_rv_data  = rand80();
    #1;
    chk("rst_wait_flags", {gptp_wr_vaild_ready, gptp_wr_ready, gptp_ts_vaild}, 3'b000);
    chk("rst_wait_ts_data", gptp_ts_data, 352'h0);
    chk("rst_wait_rd_data", gptp_rd_data, 80'h0);
    step();
    step();
    gptp_ts_rv_vaild = 1'b0;
    reset = 1'b0;
    for (int unsigned i = 0; i < 256; i++) model[i] = '0;
    seen = 0;
    repeat (3) begin
      step();
      if (gptp_wr_ready) seen++;
    end
    chk("rst_no_wr_ready", seen, 0);
    readback(8'd1);
    readback(a2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
